// File: rtl/lstm_cell_update.sv
// lstm_cell_update
// ----------------
// LSTM cell-state / hidden-state update engine. Takes already-activated gate
// values (i, f, g, o) for one hidden unit per beat and computes
//   c(t) = f * c(t-1) + i * g
//   h(t) = o * hardtanh(c(t))
// in signed fixed point (FRAC fractional bits). It keeps c(t-1) for all
// HIDDEN units in an internal register array. It also tracks the unit index
// and the number of completed timesteps.
//
// Pipeline: S1 (accept, products) -> S2 (sum, round, saturate, c write-back)
//           -> S3 (hardtanh, output product, round, saturate, output regs).
// All stages advance together on en = !out_valid || out_ready.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   gate beat handshake (in_ready = pipeline enable)
//   in_seq_start        marks unit 0 of a new sequence (sampled on accept)
//   in_i/f/g/o          activated gates, signed Q(DW-FRAC).FRAC
//   out_valid/out_ready result handshake; out_* hold while stalled
//   out_h, out_c        h(t) and c(t), signed
//   out_idx, out_last   unit index of the result, and "last unit" flag
//   t_count             completed timesteps since the last sequence start
//   err                 sticky: sequence restarted in the middle of a timestep

module lstm_cell_update #(
  parameter int DW     = 16,
  parameter int FRAC   = 12,
  parameter int HIDDEN = 64,
  parameter int TW     = 16,
  localparam int IW    = $clog2(HIDDEN)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_seq_start,
  input  logic signed [DW-1:0] in_i,
  input  logic signed [DW-1:0] in_f,
  input  logic signed [DW-1:0] in_g,
  input  logic signed [DW-1:0] in_o,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] out_h,
  output logic signed [DW-1:0] out_c,
  output logic [IW-1:0]        out_idx,
  output logic                 out_last,
  output logic [TW-1:0]        t_count,
  output logic                 err
);

  // Product and sum widths.
  localparam int PW = 2 * DW;
  localparam int SW = 2 * DW + 1;

  typedef logic signed [DW-1:0] data_t;
  typedef logic signed [PW-1:0] prod_t;
  typedef logic signed [SW-1:0] sum_t;

  // Rounding constant 2^(FRAC-1) and saturation limits, all in sum width.
  localparam sum_t  RND    = {{(SW-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
  localparam sum_t  SMAX   = {{(DW+2){1'b0}}, {(DW-1){1'b1}}};
  localparam sum_t  SMIN   = {{(DW+2){1'b1}}, {(DW-1){1'b0}}};
  localparam data_t DMAX   = {1'b0, {(DW-1){1'b1}}};
  localparam data_t DMIN   = {1'b1, {(DW-1){1'b0}}};
  // +1.0 and -1.0 in data format, used by hardtanh.
  localparam data_t ONE    = {{(DW-FRAC-1){1'b0}}, 1'b1, {FRAC{1'b0}}};
  localparam data_t NEGONE = {{(DW-FRAC){1'b1}}, {FRAC{1'b0}}};
  localparam logic [IW-1:0] LAST_IDX = IW'(HIDDEN - 1);

  // Round half-up (add half an LSB, then floor via arithmetic shift),
  // then saturate to the signed DW range.
  function automatic data_t rnd_sat(input sum_t v);
    sum_t r;
    r = (v + RND) >>> FRAC;
    if (r > SMAX) begin
      rnd_sat = DMAX;
    end else if (r < SMIN) begin
      rnd_sat = DMIN;
    end else begin
      rnd_sat = r[DW-1:0];
    end
  endfunction

  // hardtanh: clamp to [-1.0, +1.0].
  function automatic data_t hardtanh(input data_t v);
    if (v > ONE) begin
      hardtanh = ONE;
    end else if (v < NEGONE) begin
      hardtanh = NEGONE;
    end else begin
      hardtanh = v;
    end
  endfunction

  // ---------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------
  logic en;
  logic accept;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign accept   = in_valid && en;

  // ---------------------------------------------------------------------
  // Accept-time bookkeeping
  // ---------------------------------------------------------------------
  logic [IW-1:0] idx_reg;
  logic          fresh_reg;
  logic [TW-1:0] t_count_reg;
  logic          err_reg;

  // A sequence start overrides the running index and forces a fresh read.
  logic [IW-1:0] idx_use;
  logic          fresh_use;
  logic          last_use;
  data_t         c_prev;

  // c(t-1) storage, one entry per hidden unit. Not reset: fresh masks it.
  data_t cmem [HIDDEN];

  always_comb begin
    idx_use   = in_seq_start ? '0 : idx_reg;
    fresh_use = in_seq_start || fresh_reg;
    last_use  = (idx_use == LAST_IDX);
    c_prev    = fresh_use ? '0 : cmem[idx_use];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_reg     <= '0;
      fresh_reg   <= 1'b1;
      t_count_reg <= '0;
      err_reg     <= 1'b0;
    end else if (accept) begin
      if (in_seq_start) begin
        // Restarting while a timestep is partly done is a protocol error;
        // the in-flight beats are still allowed to complete.
        if (idx_reg != '0) begin
          err_reg <= 1'b1;
        end
        t_count_reg <= '0;
      end
      if (last_use) begin
        idx_reg   <= '0;
        fresh_reg <= 1'b0;
        if (t_count_reg != {TW{1'b1}}) begin
          t_count_reg <= t_count_reg + TW'(1);
        end
      end else begin
        // With HIDDEN >= 4 a start beat (idx 0) never wraps, so a start
        // coinciding with the old wrap position leaves fresh set.
        idx_reg   <= idx_use + IW'(1);
        fresh_reg <= fresh_use;
      end
    end
  end

  assign t_count = t_count_reg;
  assign err     = err_reg;

  // ---------------------------------------------------------------------
  // S1: products f*c_prev and i*g
  // ---------------------------------------------------------------------
  logic          s1_valid_reg;
  prod_t         s1_p1_reg;
  prod_t         s1_p2_reg;
  logic [IW-1:0] s1_idx_reg;
  logic          s1_last_reg;
  data_t         s1_o_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_p1_reg    <= '0;
      s1_p2_reg    <= '0;
      s1_idx_reg   <= '0;
      s1_last_reg  <= 1'b0;
      s1_o_reg     <= '0;
    end else if (en) begin
      s1_valid_reg <= accept;
      if (accept) begin
        s1_p1_reg   <= prod_t'(in_f) * prod_t'(c_prev);
        s1_p2_reg   <= prod_t'(in_i) * prod_t'(in_g);
        s1_idx_reg  <= idx_use;
        s1_last_reg <= last_use;
        s1_o_reg    <= in_o;
      end
    end
  end

  // ---------------------------------------------------------------------
  // S2: c_new = sat(round(p1 + p2)), written back to cmem
  // ---------------------------------------------------------------------
  sum_t  s2_sum;
  data_t c_new;

  always_comb begin
    s2_sum = SW'(s1_p1_reg) + SW'(s1_p2_reg);
    c_new  = rnd_sat(s2_sum);
  end

  logic          s2_valid_reg;
  data_t         s2_c_reg;
  logic [IW-1:0] s2_idx_reg;
  logic          s2_last_reg;
  data_t         s2_o_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_reg <= 1'b0;
      s2_c_reg     <= '0;
      s2_idx_reg   <= '0;
      s2_last_reg  <= 1'b0;
      s2_o_reg     <= '0;
    end else if (en) begin
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        s2_c_reg    <= c_new;
        s2_idx_reg  <= s1_idx_reg;
        s2_last_reg <= s1_last_reg;
        s2_o_reg    <= s1_o_reg;
      end
    end
  end

  // Write-back is gated by en so a stalled beat writes exactly once. The
  // same unit is read again at the earliest HIDDEN beats later, well after
  // this write, so the read path needs no forwarding.
  always_ff @(posedge clk) begin
    if (en && s1_valid_reg) begin
      cmem[s1_idx_reg] <= c_new;
    end
  end

  // ---------------------------------------------------------------------
  // S3: h = sat(round(o * hardtanh(c_new)))
  // ---------------------------------------------------------------------
  data_t ht;
  prod_t s3_prod;
  data_t h_new;

  always_comb begin
    ht      = hardtanh(s2_c_reg);
    s3_prod = prod_t'(s2_o_reg) * prod_t'(ht);
    h_new   = rnd_sat(SW'(s3_prod));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_h     <= '0;
      out_c     <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
    end else if (en) begin
      out_valid <= s2_valid_reg;
      if (s2_valid_reg) begin
        out_h    <= h_new;
        out_c    <= s2_c_reg;
        out_idx  <= s2_idx_reg;
        out_last <= s2_last_reg;
      end
    end
  end

endmodule

// File: tb/tb_lstm_cell_update.sv
// Testbench for lstm_cell_update (HIDDEN = 4).
// A reference model updated on every accepted beat predicts each result;
// a monitor compares every presented result (also while stalled) against
// the oldest prediction, and t_count/err against the model every cycle.

module tb_lstm_cell_update;

  localparam int DW     = 16;
  localparam int FRAC   = 12;
  localparam int HIDDEN = 4;
  localparam int TW     = 16;
  localparam int IW     = $clog2(HIDDEN);

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic                 in_seq_start = 1'b0;
  logic signed [DW-1:0] in_i = '0;
  logic signed [DW-1:0] in_f = '0;
  logic signed [DW-1:0] in_g = '0;
  logic signed [DW-1:0] in_o = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic signed [DW-1:0] out_h;
  logic signed [DW-1:0] out_c;
  logic [IW-1:0]        out_idx;
  logic                 out_last;
  logic [TW-1:0]        t_count;
  logic                 err;

  lstm_cell_update #(.DW(DW), .FRAC(FRAC), .HIDDEN(HIDDEN), .TW(TW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_seq_start(in_seq_start),
    .in_i(in_i), .in_f(in_f), .in_g(in_g), .in_o(in_o),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_h(out_h), .out_c(out_c), .out_idx(out_idx), .out_last(out_last),
    .t_count(t_count), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Reference model: plain integer arithmetic on the update equations.
  // ---------------------------------------------------------------------
  typedef struct {
    int h;
    int c;
    int idx;
    bit last;
  } res_t;

  res_t expq[$];
  int   m_c [HIDDEN];
  int   m_idx;
  bit   m_fresh;
  int   m_tc;
  bit   m_err;
  int   n_acc, n_out;
  int   got_c[$], got_h[$], got_idx[$];
  bit   got_last[$];

  function automatic int sat(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  // Real-valued x * 2^-FRAC rounded half-up, i.e. floor(x/2^FRAC + 1/2).
  function automatic int rnd(input longint v);
    return sat((v + (longint'(1) << (FRAC - 1))) >>> FRAC);
  endfunction

  task automatic model_clear();
    expq.delete();
    got_c.delete(); got_h.delete(); got_idx.delete(); got_last.delete();
    m_idx = 0; m_fresh = 1; m_tc = 0; m_err = 0; n_acc = 0; n_out = 0;
  endtask

  task automatic model_accept(input bit ss, input int i, input int f, input int g, input int o);
    int   u;
    int   cp;
    int   ht;
    res_t r;
    if (ss) begin
      if (m_idx != 0) m_err = 1;
      m_idx = 0; m_fresh = 1; m_tc = 0;
    end
    u    = m_idx;
    cp   = m_fresh ? 0 : m_c[u];
    r.c  = rnd(longint'(f) * cp + longint'(i) * g);
    ht   = (r.c > 4096) ? 4096 : ((r.c < -4096) ? -4096 : r.c);
    r.h  = rnd(longint'(o) * ht);
    r.idx  = u;
    r.last = (u == HIDDEN - 1);
    m_c[u] = r.c;
    expq.push_back(r);
    n_acc++;
    if (u == HIDDEN - 1) begin
      m_idx = 0; m_fresh = 0;
      if (m_tc < (1 << TW) - 1) m_tc++;
    end else begin
      m_idx = u + 1;
    end
  endtask

  // Monitor: runs on the falling edge, between the active edges.
  initial begin
    res_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("t_count", t_count, m_tc);
        chk("err", err, m_err);
        if (out_valid) begin
          if (expq.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL spurious_out: got idx=%0d c=%0d, expected no result", out_idx, out_c);
          end else begin
            e = expq[0];
            chk("out_c", out_c, e.c);
            chk("out_h", out_h, e.h);
            chk("out_idx", out_idx, e.idx);
            chk("out_last", out_last, e.last);
            if (out_ready) begin
              void'(expq.pop_front());
              n_out++;
              got_c.push_back(int'(out_c)); got_h.push_back(int'(out_h));
              got_idx.push_back(int'(out_idx)); got_last.push_back(out_last);
              $display("result idx=%0d c=%0d h=%0d last=%0b t_count=%0d err=%0b",
                       out_idx, out_c, out_h, out_last, t_count, err);
            end
          end
        end
        if (in_valid && in_ready)
          model_accept(in_seq_start, int'(in_i), int'(in_f), int'(in_g), int'(in_o));
      end
    end
  end

  function automatic int gc(input int n); return (n < got_c.size()) ? got_c[n] : -99999; endfunction
  function automatic int gh(input int n); return (n < got_h.size()) ? got_h[n] : -99999; endfunction
  function automatic int gi(input int n); return (n < got_idx.size()) ? got_idx[n] : -1; endfunction
  function automatic int gl(input int n); return (n < got_last.size()) ? int'(got_last[n]) : -1; endfunction

  // ---------------------------------------------------------------------
  // Drivers (inputs change 1 ns after the rising edge)
  // ---------------------------------------------------------------------
  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; in_seq_start = 1'b0; out_ready = 1'b1;
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic send(input bit ss, input int i, input int f, input int g, input int o);
    int cyc;
    bit acc;
    cyc = 0; acc = 0;
    in_valid = 1'b1; in_seq_start = ss;
    in_i = DW'(i); in_f = DW'(f); in_g = DW'(g); in_o = DW'(o);
    while (!acc && cyc < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("send_accepted", acc, 1);
    in_valid = 1'b0; in_seq_start = 1'b0;
  endtask

  task automatic drain();
    int cyc;
    cyc = 0;
    in_valid = 1'b0; out_ready = 1'b1;
    while (expq.size() != 0 && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("drain_empty", expq.size(), 0);
  endtask

  // ---------------------------------------------------------------------
  // Directed single-beat vectors (fresh state, so f is ignored)
  // ---------------------------------------------------------------------
  typedef struct {
    int i; int f; int g; int o;
    int c; int h;
  } vec_t;

  vec_t tbl[9];

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{i: 4096,  f: 2048, g: 2048,   o: 4096,  c: 2048,   h: 2048};
    tbl[1] = '{i: 4096,  f: 4096, g: -8192,  o: 2048,  c: -8192,  h: -2048};
    tbl[2] = '{i: 32767, f: 4096, g: 32767,  o: 4096,  c: 32767,  h: 4096};
    tbl[3] = '{i: 32767, f: 4096, g: -32768, o: 4096,  c: -32768, h: -4096};
    tbl[4] = '{i: 1,     f: 4096, g: 2048,   o: 4096,  c: 1,      h: 1};
    tbl[5] = '{i: -1,    f: 4096, g: 2048,   o: 4096,  c: 0,      h: 0};
    tbl[6] = '{i: -1,    f: 4096, g: 2049,   o: 4096,  c: -1,     h: -1};
    tbl[7] = '{i: 4096,  f: 4096, g: 3000,   o: 1365,  c: 3000,   h: 1000};
    tbl[8] = '{i: 4096,  f: 4096, g: 12000,  o: -4096, c: 12000,  h: -4096};

    // Reset state, asserted asynchronously before any clock edge.
    model_clear();
    #1 rst = 1'b1;
    #2;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_c", out_c, 0);
    chk("reset_out_h", out_h, 0);
    chk("reset_t_count", t_count, 0);
    chk("reset_err", err, 0);
    chk("reset_in_ready", in_ready, 1);
    do_reset();

    // Table: fresh beat, 3-cycle latency, exact c/h.
    for (int k = 0; k < 9; k++) begin
      do_reset();
      send(1, tbl[k].i, tbl[k].f, tbl[k].g, tbl[k].o);
      @(negedge clk);
      @(negedge clk);
      chk("latency_early", out_valid, 0);
      @(negedge clk);
      chk("latency_3", out_valid, 1);
      drain();
      chk("tbl_count", got_c.size(), 1);
      chk("tbl_c", gc(0), tbl[k].c);
      chk("tbl_h", gh(0), tbl[k].h);
      chk("tbl_idx", gi(0), 0);
      chk("tbl_err", err, 0);
    end

    // Recurrence over two timesteps.
    do_reset();
    send(1, 4096, 0, 2048, 4096);
    for (int u = 1; u < HIDDEN; u++) send(0, 2048, 1000, 4096, 4096);
    send(0, 0, 2048, 0, 4096);
    for (int u = 1; u < HIDDEN; u++) send(0, 1000, 2048, -3000, 3000);
    drain();
    chk("rec_count", got_c.size(), 8);
    chk("rec_c0", gc(0), 2048);
    chk("rec_c4", gc(4), 1024);
    chk("rec_h4", gh(4), 1024);
    chk("rec_last0", gl(0), 0);
    chk("rec_last3", gl(3), 1);
    chk("rec_last4", gl(4), 0);
    chk("rec_last7", gl(7), 1);
    chk("rec_t_count", t_count, 2);

    // Saturation through the recurrence.
    do_reset();
    send(1, 4096, 0, 30000, 4096);
    for (int u = 1; u < HIDDEN; u++) send(0, 0, 0, 0, 0);
    send(0, 4096, 4096, 4096, 4096);
    drain();
    chk("sat_c0", gc(0), 30000);
    chk("sat_h0", gh(0), 4096);
    chk("sat_c4", gc(4), 32767);
    chk("sat_h4", gh(4), 4096);

    // Random stream with random backpressure and a 5-cycle hold.
    do_reset();
    send(1, 4096, 0, 2048, 4096);
    for (int k = 0; k < 80; k++) begin
      bit hold;
      hold = (k >= 20 && k < 25);
      in_valid  = hold ? 1'b1 : ($urandom_range(0, 3) != 0);
      in_seq_start = 1'b0;
      in_i = DW'(int'($urandom_range(0, 8192)) - 4096);
      in_f = DW'(int'($urandom_range(0, 8192)) - 4096);
      in_g = DW'(int'($urandom_range(0, 16384)) - 8192);
      in_o = DW'(int'($urandom_range(0, 8192)) - 4096);
      out_ready = hold ? 1'b0 : ($urandom_range(0, 2) != 0);
      if (k == 24) begin
        @(negedge clk);
        chk("bp_out_valid", out_valid, 1);
        chk("bp_in_ready", in_ready, 0);
      end
      @(posedge clk);
      #1;
    end
    drain();
    chk("bp_no_loss", n_out, n_acc);

    // Mid-timestep restart.
    do_reset();
    send(1, 4096, 4096, 1000, 4096);
    send(0, 4096, 4096, 2000, 4096);
    chk("restart_err_before", err, 0);
    send(1, 0, 4096, 0, 4096);
    for (int u = 1; u < HIDDEN; u++) send(0, 0, 4096, 0, 4096);
    send(0, 0, 4096, 0, 4096);
    send(0, 0, 4096, 0, 4096);
    drain();
    begin
      int exp_idx[8];
      exp_idx = '{0, 1, 0, 1, 2, 3, 0, 1};
      for (int k = 0; k < 8; k++) chk("restart_idx", gi(k), exp_idx[k]);
    end
    chk("restart_c_unit1", gc(3), 0);
    chk("restart_c_next", gc(7), 0);
    chk("restart_err_sticky", err, 1);
    chk("restart_t_count", t_count, 1);

    // Asynchronous reset with beats in flight.
    do_reset();
    send(1, 4096, 0, 500, 4096);
    send(0, 4096, 0, 600, 4096);
    send(0, 4096, 0, 700, 4096);
    chk("ar_valid_before", out_valid, 1);
    #1 rst = 1'b1;
    #1;
    chk("ar_valid_async", out_valid, 0);
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("ar_quiet", out_valid, 0);
    end
    @(posedge clk);
    #1;
    send(0, 4096, 4096, 1000, 4096);
    drain();
    chk("ar_count", got_c.size(), 1);
    chk("ar_fresh_c", gc(0), 1000);
    chk("ar_fresh_h", gh(0), 1000);
    chk("ar_idx", gi(0), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
